// File: rtl/bram_stream_reader_if.sv
// Stream output bundle of bram_stream_reader: valid/ready handshake carrying
// one RAM word per transfer plus an end-of-burst marker.
interface bram_stream_reader_if #(
  parameter int DataWidth = 8
);
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [DataWidth-1:0] out_data;

  modport master (
    output out_valid,
    output out_last,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_last,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Burst reader: streams count words from a block RAM starting at base_addr.
// Define BRAM_STREAM_READER_OREG_EN to read through the RAM output register.
module bram_stream_reader #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [AddrWidth-1:0] base_addr,
  input  logic [AddrWidth:0]   count,
  output logic                 ena,
  output logic                 regcea,
  output logic                 wea,
  output logic [AddrWidth-1:0] addra,
  input  logic [DataWidth-1:0] rd_data,
  bram_stream_reader_if.master strm,
  output logic                 busy,
  output logic                 done
);

`ifdef BRAM_STREAM_READER_OREG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif
  localparam int CountW = AddrWidth + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic                 ena_q, ena_d;
  logic                 last_q, last_d;
  logic                 regcea_q, regcea_d;
  logic [AddrWidth-1:0] addra_q, addra_d;
  logic [AddrWidth-1:0] next_addr_q, next_addr_d;
  logic [CountW-1:0]    rd_left_q, rd_left_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [Lat-1:0]       pipe_vld_q, pipe_vld_d;
  logic [Lat-1:0]       pipe_last_q, pipe_last_d;

  logic [1:0]           wr_ptr_q, wr_ptr_d;
  logic [1:0]           rd_ptr_q, rd_ptr_d;
  logic [2:0]           fifo_cnt_q, fifo_cnt_d;
  logic [DataWidth-1:0] fifo_data_q [4];
  logic                 fifo_last_q [4];

  logic                 push;
  logic                 pop;
  logic                 head_valid;
  logic [2:0]           pending;
  logic [3:0]           commit;
  logic                 room;

  assign head_valid = (fifo_cnt_q != 3'd0);
  assign push       = pipe_vld_q[Lat-1];
  assign pop        = head_valid && strm.out_ready;

  // Words already promised to the FIFO: reads on the RAM port or in its pipeline.
  always_comb begin
    pending = 3'(ena_q);
    for (int i = 0; i < Lat; i++) begin
      pending = pending + 3'(pipe_vld_q[i]);
    end
  end

  // The pop happens at the same edge a new read is issued, so it frees a slot.
  assign commit = 4'(fifo_cnt_q) + 4'(pending) - 4'(pop);
  assign room   = (commit < 4'd4);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    ena_d       = 1'b0;
    last_d      = 1'b0;
    addra_d     = addra_q;
    next_addr_d = next_addr_q;
    rd_left_d   = rd_left_q;
    done_d      = 1'b0;

    pipe_vld_d[0]  = ena_q;
    pipe_last_d[0] = last_q;
    for (int i = 1; i < Lat; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            ena_d       = 1'b1;
            addra_d     = base_addr;
            next_addr_d = base_addr + AddrWidth'(1);
            rd_left_d   = count - CountW'(1);
            last_d      = (count == CountW'(1));
            state_d     = (count == CountW'(1)) ? DRAIN : RUN;
          end
        end
      end
      RUN: begin
        if (room) begin
          ena_d       = 1'b1;
          addra_d     = next_addr_q;
          next_addr_d = next_addr_q + AddrWidth'(1);
          rd_left_d   = rd_left_q - CountW'(1);
          last_d      = (rd_left_q == CountW'(1));
          if (rd_left_q == CountW'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    regcea_d   = (Lat == 2) ? ena_q : 1'b0;
    busy_d     = (state_d != IDLE);
    wr_ptr_d   = wr_ptr_q + 2'(push);
    rd_ptr_d   = rd_ptr_q + 2'(pop);
    fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ena_q       <= 1'b0;
      last_q      <= 1'b0;
      regcea_q    <= 1'b0;
      addra_q     <= '0;
      next_addr_q <= '0;
      rd_left_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ena_q       <= ena_d;
      last_q      <= last_d;
      regcea_q    <= regcea_d;
      addra_q     <= addra_d;
      next_addr_q <= next_addr_d;
      rd_left_q   <= rd_left_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // NOTE: FIFO storage is not reset; entries are only visible through a non-zero count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_last_q[wr_ptr_q] <= pipe_last_q[Lat-1];
    end
  end

  assign ena            = ena_q;
  assign regcea         = regcea_q;
  assign wea            = 1'b0;
  assign addra          = addra_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign strm.out_valid = head_valid;
  assign strm.out_data  = head_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign strm.out_last  = head_valid && fifo_last_q[rd_ptr_q];

endmodule
